// File: rtl/rca_share_arbiter.sv
// Round-robin arbiter sharing one 6-bit ripple-carry adder between NUM_REQ requesters.
// Each grant runs IDLE -> CALC (adder settle time) -> RESP (hold result until taken).
module rca_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int CALC_CYCLES = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [6*NUM_REQ-1:0]       i_req_a,
    input  logic [6*NUM_REQ-1:0]       i_req_b,
    output logic [NUM_REQ-1:0]         o_rsp_valid,
    input  logic [NUM_REQ-1:0]         i_rsp_ready,
    output logic [6:0]                 o_rsp_result,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                       o_busy
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [3:0]     counter;
    logic [GW-1:0]  last_grant;
    logic [5:0]     op_a;
    logic [5:0]     op_b;

    logic           any_valid;
    logic [GW-1:0]  winner;
    logic [GW-1:0]  cand;
    logic           found;
    logic [5:0]     sel_a;
    logic [5:0]     sel_b;
    logic           rsp_take;

    logic [6:0]     carry;
    logic [5:0]     sum_bits;
    logic [6:0]     adder_sum;

    // Ripple-carry adder fed only from the latched operands, carry-in tied low.
    always_comb begin
        carry[0] = 1'b0;
        sum_bits = '0;
        for (int i = 0; i < 6; i++) begin
            sum_bits[i]  = op_a[i] ^ op_b[i] ^ carry[i];
            carry[i+1]   = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
        end
        adder_sum = {carry[6], sum_bits};
    end

    // Round-robin search starting just after the last requester served.
    always_comb begin
        any_valid = |i_req_valid;
        winner    = last_grant;
        found     = 1'b0;
        cand      = last_grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (cand == GW'(NUM_REQ - 1)) ? '0 : cand + GW'(1);
            if (!found && i_req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == GW'(k)) begin
                sel_a = i_req_a[6*k +: 6];
                sel_b = i_req_b[6*k +: 6];
            end
        end
    end

    assign rsp_take = i_rsp_ready[o_grant_id];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_valid) next_state = CALC;
            CALC:    if (counter == 4'd0) next_state = RESP;
            RESP:    if (rsp_take) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers; the result register only loads on the last settle cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            counter      <= 4'd0;
            last_grant   <= GW'(NUM_REQ - 1);
            o_grant_id   <= '0;
            o_rsp_result <= 7'd0;
            op_a         <= 6'd0;
            op_b         <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_a       <= sel_a;
                        op_b       <= sel_b;
                        o_grant_id <= winner;
                        counter    <= 4'(CALC_CYCLES - 1);
                    end
                end
                CALC: begin
                    if (counter == 4'd0) begin
                        o_rsp_result <= adder_sum;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_take) begin
                        last_grant <= o_grant_id;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_req_ready = '0;
        o_rsp_valid = '0;
        o_busy      = (state != IDLE);
        if (state == IDLE && any_valid) begin
            o_req_ready[winner] = 1'b1;
        end
        if (state == RESP) begin
            o_rsp_valid[o_grant_id] = 1'b1;
        end
    end

endmodule

// File: tb/tb_rca_share_arbiter.sv
// Directed bench for rca_share_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_rca_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CALC_CYCLES = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    i_req_valid;
    logic [NUM_REQ-1:0]    o_req_ready;
    logic [6*NUM_REQ-1:0]  i_req_a;
    logic [6*NUM_REQ-1:0]  i_req_b;
    logic [NUM_REQ-1:0]    o_rsp_valid;
    logic [NUM_REQ-1:0]    i_rsp_ready;
    logic [6:0]            o_rsp_result;
    logic [1:0]            o_grant_id;
    logic                  o_busy;

    typedef struct {
        int         id;
        logic [6:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;

    rca_share_arbiter #(.NUM_REQ(NUM_REQ), .CALC_CYCLES(CALC_CYCLES)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_a      (i_req_a),
        .i_req_b      (i_req_b),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_result (o_rsp_result),
        .o_grant_id   (o_grant_id),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic set_operands(input int k, input logic [5:0] a, input logic [5:0] b);
        i_req_a[6*k +: 6] = a;
        i_req_b[6*k +: 6] = b;
    endtask

    task automatic push_exp(input int id, input logic [6:0] res);
        exp_t e;
        e.id  = id;
        e.res = res;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (!o_busy) done = 1'b1;
        end
        if (!done) check_output({name, "_idle_timeout"}, 0, 1);
    endtask

    task automatic apply_stimulus(input int id, input logic [5:0] a, input logic [5:0] b,
                                  input logic [6:0] res);
        @(posedge clk); #1;
        set_operands(id, a, b);
        i_req_valid = 4'(1 << id);
        i_rsp_ready = 4'b1111;
        @(negedge clk);
        check_output("single_ready", int'(o_req_ready), 1 << id);
        push_exp(id, res);
        @(posedge clk); #1;
        i_req_valid = '0;
        wait_idle("single");
    endtask

    // Scoreboard monitor: a response is consumed when valid meets the owner's ready.
    always @(negedge clk) begin
        if (rst_n && o_rsp_valid != '0 && (o_rsp_valid & i_rsp_ready) != '0) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_rsp", int'(o_rsp_result), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("rsp_valid", int'(o_rsp_valid), 1 << e.id);
                check_output("rsp_grant", int'(o_grant_id), e.id);
                check_output("rsp_result", int'(o_rsp_result), int'(e.res));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int prev_cyc;
        logic [6:0] rr_res [5];
        rst_n       = 1'b0;
        i_req_valid = '0;
        i_req_a     = '0;
        i_req_b     = '0;
        i_rsp_ready = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_output("rst_req_ready", int'(o_req_ready), 0);
        check_output("rst_rsp_valid", int'(o_rsp_valid), 0);
        check_output("rst_busy", int'(o_busy), 0);
        check_output("rst_grant", int'(o_grant_id), 0);
        check_output("rst_result", int'(o_rsp_result), 0);

        // Single request with backpressure and operand change after acceptance
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_operands(0, 6'd21, 6'd42);
        i_req_valid = 4'b0001;
        @(negedge clk);
        check_output("first_ready", int'(o_req_ready), 1);
        push_exp(0, 7'd63);
        @(posedge clk); #1;
        i_req_valid = '0;
        set_operands(0, 6'd5, 6'd5);
        @(negedge clk);
        check_output("calc_busy", int'(o_busy), 1);
        check_output("calc_no_valid", int'(o_rsp_valid), 0);
        @(negedge clk);
        check_output("calc_no_valid2", int'(o_rsp_valid), 0);
        @(negedge clk);
        check_output("lat_valid", int'(o_rsp_valid), 1);
        check_output("lat_result", int'(o_rsp_result), 63);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("hold_valid", int'(o_rsp_valid), 1);
            check_output("hold_result", int'(o_rsp_result), 63);
        end
        @(posedge clk); #1;
        i_rsp_ready = 4'b0001;
        wait_idle("first");

        // Carry-out boundaries
        apply_stimulus(1, 6'd63, 6'd1, 7'd64);
        apply_stimulus(2, 6'd63, 6'd63, 7'd126);
        apply_stimulus(3, 6'd0, 6'd0, 7'd0);

        // Round robin from reset with all requesters always valid
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        set_operands(0, 6'd5, 6'd9);
        set_operands(1, 6'd17, 6'd30);
        set_operands(2, 6'd40, 6'd33);
        set_operands(3, 6'd63, 6'd63);
        rr_res[0] = 7'd14; rr_res[1] = 7'd47; rr_res[2] = 7'd73;
        rr_res[3] = 7'd126; rr_res[4] = 7'd14;
        i_rsp_ready = 4'b1111;
        i_req_valid = 4'b1111;
        rst_n = 1'b1;
        n = 0;
        prev_cyc = 0;
        for (int i = 0; i < 60 && n < 5; i++) begin
            @(negedge clk);
            if (o_req_ready != '0) begin
                check_output("rr_order", int'(o_req_ready), 1 << (n % 4));
                if (n > 0) check_output("rr_interval", cycle - prev_cyc, CALC_CYCLES + 2);
                push_exp(n % 4, rr_res[n]);
                prev_cyc = cycle;
                n++;
            end
        end
        check_output("rr_count", n, 5);
        @(posedge clk); #1;
        i_req_valid = '0;
        wait_idle("rr");

        // Backpressure on requester 1 while requester 2 waits
        @(posedge clk); #1;
        set_operands(1, 6'd12, 6'd34);
        set_operands(2, 6'd50, 6'd20);
        i_rsp_ready = '0;
        i_req_valid = 4'b0010;
        @(negedge clk);
        check_output("bp_ready1", int'(o_req_ready), 2);
        push_exp(1, 7'd46);
        @(posedge clk); #1;
        i_req_valid = 4'b0100;
        i_rsp_ready = 4'b1101;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("bp_no_ready", int'(o_req_ready), 0);
        end
        check_output("bp_valid", int'(o_rsp_valid), 2);
        check_output("bp_result", int'(o_rsp_result), 46);
        @(posedge clk); #1;
        i_rsp_ready = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        check_output("bp_ready2", int'(o_req_ready), 4);
        push_exp(2, 7'd70);
        @(posedge clk); #1;
        i_req_valid = '0;
        i_rsp_ready = 4'b1111;
        wait_idle("bp");

        // Reset in the middle of CALC discards the transaction
        @(posedge clk); #1;
        set_operands(3, 6'd1, 6'd1);
        i_req_valid = 4'b1000;
        @(negedge clk);
        check_output("mid_ready", int'(o_req_ready), 8);
        @(posedge clk); #1;
        i_req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_busy", int'(o_busy), 0);
        check_output("mid_rst_valid", int'(o_rsp_valid), 0);
        check_output("mid_rst_grant", int'(o_grant_id), 0);
        check_output("mid_rst_result", int'(o_rsp_result), 0);
        @(posedge clk); #1;
        set_operands(0, 6'd7, 6'd8);
        i_req_valid = 4'b1001;
        check_output("mid_rst_ready", int'(o_req_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("post_rst_ready", int'(o_req_ready), 1);
        push_exp(0, 7'd15);
        @(posedge clk); #1;
        i_req_valid = '0;
        wait_idle("post_rst");

        repeat (2) @(negedge clk);
        check_output("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
